// File: rtl/conv_job_ctrl.sv
// conv_job_ctrl -- job sequencer for a convolution engine.
//
// Takes one job descriptor, streams the image into the engine input memory,
// starts the engine, waits for it to finish, then streams the results out
// through a 2-entry skid buffer.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   cfg_valid/cfg_ready/cfg_dims  job descriptor
//                                 {stride_y, stride_x, kernel_h, kernel_w,
//                                  data_h, data_w}
//   in_valid/in_ready/in_data     image stream, 4 pixels per word
//   out_valid/out_ready/out_data/out_last  result stream
//   eng_cfg                       {result_h, result_w, cfg_dims} for the engine
//   eng_mi_addr/data/wr           engine input memory write port (byte address)
//   eng_mo_addr/eng_mo_data       engine result read port (word index, 1-cycle latency)
//   eng_start/eng_done            engine kick / completion
//   busy, err                     job in progress / descriptor-reject pulse
//
// Optional build: define CONV_JOB_CTRL_PERF_EN to add the perf_load,
// perf_compute and perf_drain cycle counters for the most recent job.
module conv_job_ctrl #(
  parameter int DSIZE = 1024,
  parameter int AW    = $clog2(DSIZE) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [31:0]   cfg_dims,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_data,
  output logic          out_last,
  output logic [47:0]   eng_cfg,
  output logic [AW-1:0] eng_mi_addr,
  output logic [31:0]   eng_mi_data,
  output logic          eng_mi_wr,
  output logic [AW-1:0] eng_mo_addr,
  input  logic [31:0]   eng_mo_data,
  output logic          eng_start,
  input  logic          eng_done,
  output logic          busy,
`ifdef CONV_JOB_CTRL_PERF_EN
  output logic [31:0]   perf_load,
  output logic [31:0]   perf_compute,
  output logic [31:0]   perf_drain,
`endif
  output logic          err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_KICK,
    S_WAIT,
    S_DRAIN
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] dims_q, dims_d;
  logic [7:0]  res_w_q, res_w_d;
  logic [7:0]  res_h_q, res_h_d;
  logic [15:0] words_q, words_d;     // input words to accept in LOAD
  logic [15:0] nres_q, nres_d;       // results to drain
  logic [15:0] beat_q, beat_d;       // input word index
  logic [15:0] rd_idx_q, rd_idx_d;   // next result index to read
  logic        pend_q, pend_d;       // a read is in flight (data arrives this cycle)
  logic        pend_last_q, pend_last_d;
  logic [1:0]  cnt_q, cnt_d;         // skid buffer occupancy
  logic [31:0] buf0_q, buf0_d;       // head entry, drives out_data
  logic [31:0] buf1_q, buf1_d;
  logic        last0_q, last0_d;
  logic        last1_q, last1_d;
  logic        err_q, err_d;
  logic        cfg_ready_q, cfg_ready_d;
`ifdef CONV_JOB_CTRL_PERF_EN
  logic [31:0] perf_load_q, perf_load_d;
  logic [31:0] perf_compute_q, perf_compute_d;
  logic [31:0] perf_drain_q, perf_drain_d;
`endif

  // Descriptor decode
  logic [7:0]  c_dw, c_dh;
  logic [3:0]  c_kw, c_kh, c_sx, c_sy;
  logic [3:0]  c_sx_nz, c_sy_nz;
  logic [15:0] c_area;
  logic [7:0]  c_rw, c_rh;
  logic [15:0] c_words;
  logic [15:0] c_nres;
  logic        c_bad;

  assign c_dw    = cfg_dims[7:0];
  assign c_dh    = cfg_dims[15:8];
  assign c_kw    = cfg_dims[19:16];
  assign c_kh    = cfg_dims[23:20];
  assign c_sx    = cfg_dims[27:24];
  assign c_sy    = cfg_dims[31:28];
  // Zero strides are rejected; substitute 1 so the divider never sees 0.
  assign c_sx_nz = (c_sx == 4'd0) ? 4'd1 : c_sx;
  assign c_sy_nz = (c_sy == 4'd0) ? 4'd1 : c_sy;
  assign c_area  = {8'd0, c_dw} * {8'd0, c_dh};
  assign c_rw    = (c_dw - {4'd0, c_kw}) / {4'd0, c_sx_nz};
  assign c_rh    = (c_dh - {4'd0, c_kh}) / {4'd0, c_sy_nz};
  // Area is at most 255*255, so adding 3 cannot overflow 16 bits.
  assign c_words = (c_area + 16'd3) >> 2;
  assign c_nres  = {8'd0, c_rw} * {8'd0, c_rh};
  assign c_bad   = (c_sx == 4'd0) || (c_sy == 4'd0) ||
                   (c_kw == 4'd0) || (c_kh == 4'd0) ||
                   ({4'd0, c_kw} > c_dw) || ({4'd0, c_kh} > c_dh) ||
                   ({16'd0, c_area} > 32'(DSIZE));

  // Skid buffer control
  logic       pop;
  logic       issue;
  logic [1:0] occ;
  logic [1:0] cnt_pop;

  assign out_valid   = (state_q == S_DRAIN) && (cnt_q != 2'd0);
  assign out_data    = buf0_q;
  assign out_last    = out_valid && last0_q;
  assign cfg_ready   = cfg_ready_q;
  assign err         = err_q;
  assign busy        = (state_q != S_IDLE);
  assign eng_cfg     = {res_h_q, res_w_q, dims_q};
  assign eng_mi_addr = AW'({beat_q, 2'b00});
  assign eng_mi_data = in_data;
  assign eng_mo_addr = AW'(rd_idx_q);
`ifdef CONV_JOB_CTRL_PERF_EN
  assign perf_load    = perf_load_q;
  assign perf_compute = perf_compute_q;
  assign perf_drain   = perf_drain_q;
`endif

  always_comb begin
    state_d     = state_q;
    dims_d      = dims_q;
    res_w_d     = res_w_q;
    res_h_d     = res_h_q;
    words_d     = words_q;
    nres_d      = nres_q;
    beat_d      = beat_q;
    rd_idx_d    = rd_idx_q;
    pend_d      = 1'b0;
    pend_last_d = pend_last_q;
    cnt_d       = cnt_q;
    buf0_d      = buf0_q;
    buf1_d      = buf1_q;
    last0_d     = last0_q;
    last1_d     = last1_q;
    err_d       = 1'b0;
    in_ready    = 1'b0;
    eng_mi_wr   = 1'b0;
    eng_start   = 1'b0;
    issue       = 1'b0;
    pop         = out_valid && out_ready;
    occ         = cnt_q + {1'b0, pend_q};
    cnt_pop     = cnt_q - {1'b0, pop};
`ifdef CONV_JOB_CTRL_PERF_EN
    perf_load_d    = perf_load_q;
    perf_compute_d = perf_compute_q;
    perf_drain_d   = perf_drain_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (cfg_valid && cfg_ready_q) begin
          if (c_bad) begin
            err_d = 1'b1;
          end else begin
            dims_d   = cfg_dims;
            res_w_d  = c_rw;
            res_h_d  = c_rh;
            words_d  = c_words;
            nres_d   = c_nres;
            beat_d   = 16'd0;
            rd_idx_d = 16'd0;
            state_d  = S_LOAD;
`ifdef CONV_JOB_CTRL_PERF_EN
            perf_load_d    = 32'd0;
            perf_compute_d = 32'd0;
            perf_drain_d   = 32'd0;
`endif
          end
        end
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          eng_mi_wr = 1'b1;
          beat_d    = beat_q + 16'd1;
          if (beat_q == words_q - 16'd1) state_d = S_KICK;
        end
      end
      S_KICK: begin
        eng_start = 1'b1;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (eng_done) state_d = (nres_q == 16'd0) ? S_IDLE : S_DRAIN;
      end
      S_DRAIN: begin
        // Issue only if the data returning next cycle is guaranteed a slot:
        // buffered + in-flight entries must leave room after this cycle's pop.
        issue = (rd_idx_q != nres_q) && ((occ < 2'd2) || pop);
        if (issue) begin
          rd_idx_d    = rd_idx_q + 16'd1;
          pend_d      = 1'b1;
          pend_last_d = (rd_idx_q == nres_q - 16'd1);
        end
        if (pop && last0_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Skid buffer: pop shifts entry 1 to the head, then returning read data
    // lands in the first free slot.
    if (pop) begin
      buf0_d  = buf1_q;
      last0_d = last1_q;
    end
    if (pend_q) begin
      if (cnt_pop == 2'd0) begin
        buf0_d  = eng_mo_data;
        last0_d = pend_last_q;
      end else begin
        buf1_d  = eng_mo_data;
        last1_d = pend_last_q;
      end
    end
    cnt_d = cnt_pop + {1'b0, pend_q};

`ifdef CONV_JOB_CTRL_PERF_EN
    if (state_q == S_LOAD) perf_load_d = perf_load_q + 32'd1;
    if ((state_q == S_KICK) || (state_q == S_WAIT)) perf_compute_d = perf_compute_q + 32'd1;
    if (state_q == S_DRAIN) perf_drain_d = perf_drain_q + 32'd1;
`endif

    cfg_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      dims_q      <= '0;
      res_w_q     <= '0;
      res_h_q     <= '0;
      words_q     <= '0;
      nres_q      <= '0;
      beat_q      <= '0;
      rd_idx_q    <= '0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
      cnt_q       <= '0;
      buf0_q      <= '0;
      buf1_q      <= '0;
      last0_q     <= 1'b0;
      last1_q     <= 1'b0;
      err_q       <= 1'b0;
      cfg_ready_q <= 1'b0;
`ifdef CONV_JOB_CTRL_PERF_EN
      perf_load_q    <= '0;
      perf_compute_q <= '0;
      perf_drain_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      dims_q      <= dims_d;
      res_w_q     <= res_w_d;
      res_h_q     <= res_h_d;
      words_q     <= words_d;
      nres_q      <= nres_d;
      beat_q      <= beat_d;
      rd_idx_q    <= rd_idx_d;
      pend_q      <= pend_d;
      pend_last_q <= pend_last_d;
      cnt_q       <= cnt_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
      last0_q     <= last0_d;
      last1_q     <= last1_d;
      err_q       <= err_d;
      cfg_ready_q <= cfg_ready_d;
`ifdef CONV_JOB_CTRL_PERF_EN
      perf_load_q    <= perf_load_d;
      perf_compute_q <= perf_compute_d;
      perf_drain_q   <= perf_drain_d;
`endif
    end
  end

endmodule

// File: tb/tb_conv_job_ctrl.sv
// Directed bench for conv_job_ctrl: reset state, descriptor rejects, full
// jobs with several geometries and handshake patterns, mid-job reset.
module tb_conv_job_ctrl;
  localparam int DSIZE = 1024;
  localparam int AW    = $clog2(DSIZE) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [31:0]   cfg_dims;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_data;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic          out_last;
  logic [47:0]   eng_cfg;
  logic [AW-1:0] eng_mi_addr;
  logic [31:0]   eng_mi_data;
  logic          eng_mi_wr;
  logic [AW-1:0] eng_mo_addr;
  logic [31:0]   eng_mo_data;
  logic          eng_start;
  logic          eng_done;
  logic          busy;
  logic          err;

  conv_job_ctrl #(.DSIZE(DSIZE)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_dims(cfg_dims),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .eng_cfg(eng_cfg),
    .eng_mi_addr(eng_mi_addr), .eng_mi_data(eng_mi_data), .eng_mi_wr(eng_mi_wr),
    .eng_mo_addr(eng_mo_addr), .eng_mo_data(eng_mo_data),
    .eng_start(eng_start), .eng_done(eng_done),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Engine result memory model: result word i reads back as {C0DE, i}.
  always @(posedge clk) eng_mo_data <= {16'hC0DE, 16'(eng_mo_addr)};

  // Transaction logs, sampled on the falling edge.
  logic [AW-1:0] mi_addr_log [0:511];
  logic [31:0]   mi_data_log [0:511];
  logic [31:0]   out_log     [0:511];
  logic          last_log    [0:511];
  int mi_cnt    = 0;
  int out_cnt   = 0;
  int start_cnt = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (eng_mi_wr) begin
        mi_addr_log[mi_cnt % 512] <= eng_mi_addr;
        mi_data_log[mi_cnt % 512] <= eng_mi_data;
        mi_cnt <= mi_cnt + 1;
      end
      if (out_valid && out_ready) begin
        out_log[out_cnt % 512]  <= out_data;
        last_log[out_cnt % 512] <= out_last;
        out_cnt <= out_cnt + 1;
      end
      if (eng_start) start_cnt <= start_cnt + 1;
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_cfg(input logic [31:0] dims);
    @(posedge clk); #1;
    cfg_dims  = dims;
    cfg_valid = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic load_words(input string tag, input int nwords, input bit rnd);
    int k;
    int guard;
    bit acc;
    k = 0;
    guard = 0;
    while (k < nwords && guard < 2000) begin
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = 32'h1000_0000 + k;
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) k++;
      guard++;
    end
    in_valid = 1'b0;
    check({tag, " words accepted"}, k, nwords);
  endtask

  task automatic wait_start(input int st0);
    int guard;
    guard = 0;
    while (start_cnt == st0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic do_job(input string tag, input logic [31:0] dims, input logic [47:0] exp_cfg,
                        input int nwords, input int nres, input bit rnd);
    int mi0, out0, st0, guard;
    mi0  = mi_cnt;
    out0 = out_cnt;
    st0  = start_cnt;
    send_cfg(dims);
    check({tag, " busy after capture"}, busy, 1);
    check({tag, " eng_cfg"}, eng_cfg, exp_cfg);
    load_words(tag, nwords, rnd);
    wait_start(st0);
    @(negedge clk);
    check({tag, " in_ready low in WAIT"}, in_ready, 0);
    repeat (3) @(posedge clk);
    #1 eng_done = 1'b1;
    @(posedge clk); #1;
    eng_done = 1'b0;
    guard = 0;
    while (busy && guard < 2000) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      guard++;
    end
    out_ready = 1'b0;
    @(negedge clk); #1;
    check({tag, " returned to idle"}, busy, 0);
    check({tag, " cfg_ready in idle"}, cfg_ready, 1);
    check({tag, " eng_cfg held"}, eng_cfg, exp_cfg);
    check({tag, " eng_start pulses"}, start_cnt - st0, 1);
    check({tag, " mi beats"}, mi_cnt - mi0, nwords);
    for (int i = 0; i < nwords; i++) begin
      check({tag, " mi addr"}, mi_addr_log[(mi0 + i) % 512], 4 * i);
      check({tag, " mi data"}, mi_data_log[(mi0 + i) % 512], 32'h1000_0000 + i);
    end
    check({tag, " out beats"}, out_cnt - out0, nres);
    for (int i = 0; i < nres; i++) begin
      check({tag, " out data"}, out_log[(out0 + i) % 512], {16'hC0DE, 16'(i)});
      check({tag, " out last"}, last_log[(out0 + i) % 512], (i == nres - 1) ? 1 : 0);
    end
  endtask

  task automatic reject(input string tag, input logic [31:0] dims);
    send_cfg(dims);
    check({tag, " err pulse"}, err, 1);
    check({tag, " cfg_ready kept"}, cfg_ready, 1);
    check({tag, " in_ready low"}, in_ready, 0);
    check({tag, " not busy"}, busy, 0);
    @(posedge clk); #1;
    check({tag, " err one cycle"}, err, 0);
    check({tag, " still idle"}, in_ready, 0);
  endtask

  initial begin
    int st0;
    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    cfg_dims  = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    eng_done  = 1'b0;
    #1;
    check("reset cfg_ready", cfg_ready, 0);
    check("reset busy", busy, 0);
    check("reset out_valid", out_valid, 0);
    check("reset eng_start", eng_start, 0);
    check("reset err", err, 0);
    #20;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("cfg_ready after reset", cfg_ready, 1);

    // 8x8 image, 3x3 kernel, stride 1: 5x5 results
    do_job("s1", 32'h1133_0808, 48'h0505_1133_0808, 16, 25, 1'b0);
    // stride 2: 2x2 results
    do_job("s2", 32'h2233_0808, 48'h0202_2233_0808, 16, 4, 1'b0);
    // 9x6 image, 3x2 kernel, stride x=2 y=1: 3x4 results, 54 bytes -> 14 words
    do_job("odd", 32'h1223_0609, 48'h0403_1223_0609, 14, 12, 1'b0);
    // kernel equals image: no results, DRAIN skipped
    do_job("empty", 32'h1188_0808, 48'h0000_1188_0808, 16, 0, 1'b0);
    // random in_valid / out_ready during 25-result job
    do_job("rnd", 32'h1133_0808, 48'h0505_1133_0808, 16, 25, 1'b1);

    reject("kw>dw", 32'h1139_0808);
    reject("area", 32'h1133_2040);
    reject("stride0", 32'h0133_0808);

    // Reset while waiting on the engine
    st0 = start_cnt;
    send_cfg(32'h1133_0808);
    load_words("rstjob", 16, 1'b0);
    wait_start(st0);
    @(posedge clk); #1;
    check("pre-reset busy in WAIT", busy, 1);
    check("pre-reset mi addr", eng_mi_addr, 64);
    #1 rst_n = 1'b0;
    #1;
    check("rst busy", busy, 0);
    check("rst cfg_ready", cfg_ready, 0);
    check("rst in_ready", in_ready, 0);
    check("rst out_valid", out_valid, 0);
    check("rst out_last", out_last, 0);
    check("rst eng_mi_wr", eng_mi_wr, 0);
    check("rst eng_start", eng_start, 0);
    check("rst err", err, 0);
    check("rst mi addr", eng_mi_addr, 0);
    check("rst mo addr", eng_mo_addr, 0);
    check("rst eng_cfg", eng_cfg, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("cfg_ready after mid-job reset", cfg_ready, 1);
    eng_done = 1'b1;
    @(posedge clk); #1;
    eng_done = 1'b0;
    @(posedge clk); #1;
    check("late done ignored busy", busy, 0);
    check("late done ignored out_valid", out_valid, 0);
    do_job("after rst", 32'h2233_0808, 48'h0202_2233_0808, 16, 4, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/conv_job_ctrl.md
CONV_JOB_CTRL -- requirements
Module: conv_job_ctrl

Interface
REQ-001 SHALL have parameter DSIZE, default 1024, engine input memory size in bytes.
REQ-002 SHALL have derived parameter AW, default $clog2(DSIZE)+1, engine address width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port cfg_valid / cfg_ready  input / output  1 / 1  job descriptor handshake.
REQ-006 SHALL have port cfg_dims  input  32  {stride_y[3:0], stride_x[3:0], kernel_h[3:0], kernel_w[3:0], data_h[7:0], data_w[7:0]}.
REQ-007 SHALL have port in_valid / in_ready / in_data  input / output / input  1 / 1 / 32  image stream, 4 pixels per word, byte 0 first.
REQ-008 SHALL have port out_valid / out_ready / out_data / out_last  output / input / output / output  1 / 1 / 32 / 1  result stream.
REQ-009 SHALL have port eng_cfg  output  48  {result_h[7:0], result_w[7:0], cfg_dims}, held stable for the whole job.
REQ-010 SHALL have ports eng_mi_addr / eng_mi_data / eng_mi_wr  output  AW / 32 / 1  engine input memory write port, byte address.
REQ-011 SHALL have ports eng_mo_addr / eng_mo_data  output / input  AW / 32  engine result read port, one result per word.
REQ-012 SHALL have ports eng_start / eng_done  output / input  1 / 1  engine kick and completion.
REQ-013 SHALL have ports busy / err  output  1 / 1  job in progress; one-cycle descriptor-reject pulse.

Function
REQ-014 SHALL implement FSM IDLE -> LOAD -> KICK -> WAIT -> DRAIN -> IDLE.
REQ-015 SHALL assert cfg_ready only in IDLE; descriptor captured on cfg_valid & cfg_ready.
REQ-016 SHALL compute result_w = (data_w - kernel_w) / stride_x and result_h = (data_h - kernel_h) / stride_y, integer division, at capture.
REQ-017 SHALL reject (1-cycle err, remain IDLE) when a stride or kernel dimension is 0, kernel_w > data_w, kernel_h > data_h, or data_w*data_h > DSIZE.
REQ-018 SHALL, in LOAD, set in_ready=1 and on each in beat drive eng_mi_wr=1, eng_mi_data=in_data, eng_mi_addr=4*n (n = beat index from 0) in the same cycle.
REQ-019 SHALL accept exactly ceil(data_w*data_h/4) words in LOAD, then go to KICK.
REQ-020 SHALL pulse eng_start for exactly one cycle in KICK, then enter WAIT.
REQ-021 SHALL leave WAIT on the first cycle eng_done=1; eng_done is ignored in all other states.
REQ-022 SHALL, in DRAIN, read indices 0 .. result_w*result_h-1 in order on eng_mo_addr; eng_mo_data is valid one cycle after its address.
REQ-023 SHALL hold reads in a 2-entry skid buffer so out_data is never dropped or duplicated under any out_ready pattern.
REQ-024 SHALL assert out_last with the final result beat; FSM returns to IDLE on its acceptance.
REQ-025 SHALL skip DRAIN and return to IDLE after WAIT when result_w*result_h = 0 (no output beats).
REQ-026 SHALL keep out_valid stable with constant out_data until out_ready.
REQ-027 SHALL drive busy=1 in every state except IDLE.

Reset
REQ-028 SHALL, on rst_n low at any time including mid-job, asynchronously force IDLE and clear cfg_ready, in_ready, out_valid, out_last, eng_mi_wr, eng_start, err, busy, eng_mi_addr, eng_mo_addr and skid buffer.
REQ-029 SHALL assert cfg_ready in the first cycle after rst_n deasserts.

Configuration
REQ-030 SHALL, with macro CONV_JOB_CTRL_PERF_EN defined, add 32-bit outputs perf_load, perf_compute, perf_drain counting cycles spent in LOAD, KICK+WAIT, DRAIN of the last job, cleared at descriptor capture and by reset.
REQ-031 SHALL, without CONV_JOB_CTRL_PERF_EN, omit those ports and counters entirely.

Verification
REQ-032 SHALL cover: 8x8 image, 3x3 kernel, stride 1 -> 16 eng_mi_wr beats at 0,4,..,60; one eng_start; 25 out beats, out_last on 25th.
REQ-033 SHALL cover: 8x8, 3x3, stride 2 -> eng_cfg result_w=result_h=2; 4 out beats read at mo_addr 0..3.
REQ-034 SHALL cover: kernel_w=9, data_w=8 -> err 1 cycle, no in_ready, cfg_ready stays 1.
REQ-035 SHALL cover: out_ready toggled randomly during 25-result drain -> results 0..24 in order, none lost or repeated.
REQ-036 SHALL cover: rst_n low in WAIT -> all outputs cleared immediately; late eng_done ignored; next job completes normally.
